pixel_resolve: RTL and testbench
================================

// Module: pixel_resolve
// PURPOSE
// - Sits directly downstream of the path-trace pixel pipe and consumes its ray_color write stream.
// - Captures the final L colour of each of the 2^RPP_WIDTH rays of one pixel and averages them once the pixel pipe drops busy.
// - Converts the average to 8-bit RGB and hands {x, y, rgb} to the framebuffer writer over a valid/ready handshake.
// PARAMETERS
// - RPP_WIDTH  `RPP_WIDTH  log2(rays per pixel); RPP = 2**RPP_WIDTH
// - PX_WIDTH   `PX_WIDTH   pixel x coordinate width
// - PY_WIDTH   `PY_WIDTH   pixel y coordinate width
// PORTS
// - clk             in   1          clock
// - rst             in   1          reset, synchronous, active-high
// - pixel_start     in   1          pulse: new pixel issued to the pixel pipe; x/y valid this cycle
// - pixel_x         in   PX_WIDTH   pixel x, sampled on pixel_start
// - pixel_y         in   PY_WIDTH   pixel y, sampled on pixel_start
// - pixel_busy      in   1          busy of the pixel pipe
// - color_wr_en     in   1          ray colour write strobe
// - color_ndx       in   RPP_WIDTH  ray index of the write
// - color           in   96         vec3_t, three IEEE-754 float32 channels {r,g,b}
// - busy            out  1          high from pixel_start until the fb handshake completes
// - fb_valid        out  1          resolved pixel available
// - fb_ready        in   1          framebuffer writer accepts
// - fb_x / fb_y     out  PX/PY      coordinates of resolved pixel
// - fb_rgb          out  24         rgb8_t {r[7:0], g[7:0], b[7:0]}
// - err_overrun     out  1          sticky: pixel_start or color_wr_en arrived outside S_COLLECT
// BEHAVIOUR
// - Reset: state S_IDLE; busy=0, fb_valid=0, fb_x/fb_y/fb_rgb=0, err_overrun=0; all valid bits cleared.
// - FSM: S_IDLE -> S_COLLECT on pixel_start (latch x/y, clear all RPP valid bits, same cycle).
// - S_COLLECT: color_wr_en writes color to colour buffer[color_ndx] and sets valid[color_ndx]; repeated writes to one index: last wins.
// - S_COLLECT -> S_READ on the first cycle pixel_busy is sampled 0 after having been sampled 1 since pixel_start.
// - S_READ: issue read addresses 0..RPP-1 one per cycle (RPP cycles) -> S_DRAIN.
// - Read pipe: buffer read 1 cycle; convert stage registered 1 cycle; accumulate on the following edge.
// - S_DRAIN: 2 cycles to flush the pipe, then register fb_rgb and enter S_OUT with fb_valid=1.
// - fb_valid rises exactly RPP+3 cycles after the S_COLLECT->S_READ transition cycle.
// - S_OUT: fb_valid/fb_x/fb_y/fb_rgb held stable until fb_valid&fb_ready; that cycle -> S_IDLE, fb_valid=0 next cycle.
// - Entries with valid=0 contribute 0.0 (no stale data from the previous pixel).
// - Conversion per channel to unorm16 (U0.16), e = exp field, m = {1,mant[22:0]}:
//   sign=1 or e==0 -> 0; e>=127 (>=1.0, Inf, NaN) -> 16'hFFFF; shift=134-e; shift>=24 -> 0; else m>>shift.
// - Accumulator: per channel 16+RPP_WIDTH bits unsigned, cleared on entering S_READ; no overflow possible.
// - Average = acc >> RPP_WIDTH (truncate); channel8 = avg[15:8].
// - color_wr_en or pixel_start outside S_COLLECT/S_IDLE respectively: ignored, err_overrun set; cleared only by rst.
// - pixel_start in S_COLLECT: ignored, err_overrun set.
// - rst mid-operation: returns to S_IDLE next cycle, fb_valid=0, pending pixel discarded.
// STRUCTURE
// - Shared package (defines.svh): rgb8_t struct, UNORM16_ONE = 16'hFFFF, FLOAT_EXP_BIAS = 127.
// - Colour storage: existing bram_1r1w, ADDR_WIDTH=RPP_WIDTH, DATA_WIDTH=$bits(vec3_t); valid bits in flops.
// - Sub-module float_to_unorm16 (combinational, one float32 in, 16-bit out), instanced 3x.
// TESTING
// - All 64 rays = 1.0 (32'h3f800000) -> fb_rgb=24'hFFFFFF, fb_valid at RPP+3 cycles after busy fall.
// - All rays = 0.5 (32'h3f000000) -> fb_rgb=24'h808080; rays 0..31=1.0, 32..63=0.0 -> 24'h7F7F7F.
// - Only ndx 0 written, r=1.0 g=b=0 -> fb_rgb=24'h030000 (unwritten entries read as 0, even after a prior all-1.0 pixel).
// - ndx 5 written -1.0 then 2.0; ndx 6 NaN 32'h7fc00000; others 0 -> r avg = 2*FFFF>>6 -> fb_rgb r=8'h07.
// - fb_ready held 0 for 5 cycles in S_OUT -> fb_valid/fb_rgb/fb_x/fb_y stable, busy=1; accepted on 6th, S_IDLE next.
// - color_wr_en during S_READ -> ignored, err_overrun=1 sticky; rst during S_READ -> fb_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/pixel_resolve_pkg.sv
// Shared types and constants for the pixel resolve block: float vectors in,
// 8-bit RGB out, plus the resolve FSM state encoding.
package pixel_resolve_pkg;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
    } vec3_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    localparam logic [15:0] UNORM16_ONE    = 16'hFFFF;
    localparam logic [7:0]  FLOAT_EXP_BIAS = 8'd127;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_READ,
        S_DRAIN,
        S_OUT
    } state_t;

endpackage

// File: rtl/bram_1r1w.sv
// Simple dual-port block RAM: one synchronous write port, one registered read port.
module bram_1r1w #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 96
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [1<<ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data <= mem_q[rd_addr];
    end

endmodule

// File: rtl/float_to_unorm16.sv
// Combinational float32 -> U0.16 conversion; negatives clamp to 0, >=1.0/Inf/NaN to all-ones.
module float_to_unorm16
    import pixel_resolve_pkg::*;
(
    input  logic [31:0] f,
    output logic [15:0] u
);

    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  shift;

    always_comb begin
        e     = f[30:23];
        m     = {1'b1, f[22:0]};
        // value * 2^16 == m >> (134 - e) for normal inputs below 1.0
        shift = 8'd134 - e;
        u     = '0;
        if (f[31] || (e == 8'd0)) begin
            u = '0;
        end else if (e >= FLOAT_EXP_BIAS) begin
            u = UNORM16_ONE;
        end else if (shift >= 8'd24) begin
            u = '0;
        end else begin
            u = 16'(m >> shift);
        end
    end

endmodule

// File: rtl/pixel_resolve.sv
// Collects per-ray colours of one pixel, averages them once the pixel pipe idles,
// and hands the 8-bit RGB result to the framebuffer writer.
module pixel_resolve
    import pixel_resolve_pkg::*;
#(
    parameter int RPP_WIDTH = 6,
    parameter int PX_WIDTH  = 10,
    parameter int PY_WIDTH  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pixel_start,
    input  logic [PX_WIDTH-1:0]  pixel_x,
    input  logic [PY_WIDTH-1:0]  pixel_y,
    input  logic                 pixel_busy,
    input  logic                 color_wr_en,
    input  logic [RPP_WIDTH-1:0] color_ndx,
    input  logic [95:0]          color,
    output logic                 busy,
    output logic                 fb_valid,
    input  logic                 fb_ready,
    output logic [PX_WIDTH-1:0]  fb_x,
    output logic [PY_WIDTH-1:0]  fb_y,
    output logic [23:0]          fb_rgb,
    output logic                 err_overrun
);

    localparam int RPP   = 1 << RPP_WIDTH;
    localparam int ACC_W = 16 + RPP_WIDTH;

    function automatic logic [7:0] to_ch8(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] avg;
        avg = acc >> RPP_WIDTH;
        return avg[15:8];
    endfunction

    state_t                state_q, state_d;
    logic                  seen_busy_q, seen_busy_d;
    logic [RPP_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic                  drain_cnt_q, drain_cnt_d;
    logic [RPP-1:0]        valid_q, valid_d;
    logic [PX_WIDTH-1:0]   px_q, px_d;
    logic [PY_WIDTH-1:0]   py_q, py_d;
    logic                  err_q, err_d;
    logic                  fb_valid_q, fb_valid_d;
    logic [PX_WIDTH-1:0]   fb_x_q, fb_x_d;
    logic [PY_WIDTH-1:0]   fb_y_q, fb_y_d;
    rgb8_t                 fb_rgb_q, fb_rgb_d;

    logic                  vld_p1_q, vld_p1_d;
    logic                  ok_p1_q, ok_p1_d;
    logic [95:0]           rd_data_p1;
    vec3_t                 rd_vec_p1;
    logic [15:0]           unorm_p1 [3];
    logic                  vld_p2_q, vld_p2_d;
    logic [15:0]           conv_p2_q [3];
    logic [15:0]           conv_p2_d [3];
    logic [ACC_W-1:0]      acc_q [3];
    logic [ACC_W-1:0]      acc_d [3];

    logic                  buf_wr_en;
    logic                  enter_read;
    logic                  drain_done;

    assign buf_wr_en  = color_wr_en && (state_q == S_COLLECT);
    assign enter_read = (state_q == S_COLLECT) && seen_busy_q && !pixel_busy;
    assign drain_done = (state_q == S_DRAIN) && drain_cnt_q;

    // p0 -> p1: colour buffer read, address driven by the read counter
    bram_1r1w #(
        .ADDR_WIDTH (RPP_WIDTH),
        .DATA_WIDTH ($bits(vec3_t))
    ) u_color_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (color_ndx),
        .wr_data (color),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data_p1)
    );

    assign rd_vec_p1 = rd_data_p1;

    float_to_unorm16 u_cvt_r (.f(rd_vec_p1.r), .u(unorm_p1[0]));
    float_to_unorm16 u_cvt_g (.f(rd_vec_p1.g), .u(unorm_p1[1]));
    float_to_unorm16 u_cvt_b (.f(rd_vec_p1.b), .u(unorm_p1[2]));

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        rd_cnt_d    = rd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        valid_d     = valid_q;
        px_d        = px_q;
        py_d        = py_q;
        fb_valid_d  = fb_valid_q;
        err_d       = err_q | (color_wr_en && (state_q != S_COLLECT))
                            | (pixel_start && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (pixel_start) begin
                    state_d     = S_COLLECT;
                    px_d        = pixel_x;
                    py_d        = pixel_y;
                    valid_d     = '0;
                    seen_busy_d = 1'b0;
                end
            end
            S_COLLECT: begin
                if (buf_wr_en) begin
                    valid_d[color_ndx] = 1'b1;
                end
                seen_busy_d = seen_busy_q | pixel_busy;
                if (enter_read) begin
                    state_d  = S_READ;
                    rd_cnt_d = '0;
                end
            end
            S_READ: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (&rd_cnt_q) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = 1'b1;
                if (drain_done) begin
                    state_d    = S_OUT;
                    fb_valid_d = 1'b1;
                end
            end
            S_OUT: begin
                if (fb_ready) begin
                    state_d    = S_IDLE;
                    fb_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // p1 -> p2: mask unwritten entries, register the converted channels
    always_comb begin
        vld_p1_d = (state_q == S_READ);
        ok_p1_d  = valid_q[rd_cnt_q];
        vld_p2_d = vld_p1_q;
        for (int ch = 0; ch < 3; ch++) begin
            conv_p2_d[ch] = ok_p1_q ? unorm_p1[ch] : 16'd0;
        end
    end

    // p2 -> acc: accumulate on the edge after conversion
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            acc_d[ch] = acc_q[ch];
            if (enter_read) begin
                acc_d[ch] = '0;
            end else if (vld_p2_q) begin
                acc_d[ch] = acc_q[ch] + ACC_W'(conv_p2_q[ch]);
            end
        end
    end

    // The last accumulate and the output register share one edge, so read acc_d.
    always_comb begin
        fb_x_d   = fb_x_q;
        fb_y_d   = fb_y_q;
        fb_rgb_d = fb_rgb_q;
        if (drain_done) begin
            fb_x_d     = px_q;
            fb_y_d     = py_q;
            fb_rgb_d.r = to_ch8(acc_d[0]);
            fb_rgb_d.g = to_ch8(acc_d[1]);
            fb_rgb_d.b = to_ch8(acc_d[2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seen_busy_q <= 1'b0;
            drain_cnt_q <= 1'b0;
            valid_q     <= '0;
            err_q       <= 1'b0;
            fb_valid_q  <= 1'b0;
            fb_x_q      <= '0;
            fb_y_q      <= '0;
            fb_rgb_q    <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
            drain_cnt_q <= drain_cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            fb_valid_q  <= fb_valid_d;
            fb_x_q      <= fb_x_d;
            fb_y_q      <= fb_y_d;
            fb_rgb_q    <= fb_rgb_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_cnt_q <= rd_cnt_d;
        px_q     <= px_d;
        py_q     <= py_d;
        ok_p1_q  <= ok_p1_d;
        for (int ch = 0; ch < 3; ch++) begin
            conv_p2_q[ch] <= conv_p2_d[ch];
            acc_q[ch]     <= acc_d[ch];
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign fb_valid    = fb_valid_q;
    assign fb_x        = fb_x_q;
    assign fb_y        = fb_y_q;
    assign fb_rgb      = fb_rgb_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_pixel_resolve.sv
// Directed bench for pixel_resolve with an arithmetic reference model and a per-cycle checker.
module tb_pixel_resolve;

    localparam int RPP_WIDTH = 6;
    localparam int RPP       = 1 << RPP_WIDTH;
    localparam int PX_WIDTH  = 10;
    localparam int PY_WIDTH  = 10;

    localparam logic [31:0] F_ONE  = 32'h3f800000;
    localparam logic [31:0] F_HALF = 32'h3f000000;
    localparam logic [31:0] F_NEG1 = 32'hbf800000;
    localparam logic [31:0] F_TWO  = 32'h40000000;
    localparam logic [31:0] F_NAN  = 32'h7fc00000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pixel_start;
    logic [PX_WIDTH-1:0]  pixel_x;
    logic [PY_WIDTH-1:0]  pixel_y;
    logic                 pixel_busy;
    logic                 color_wr_en;
    logic [RPP_WIDTH-1:0] color_ndx;
    logic [95:0]          color;
    logic                 busy;
    logic                 fb_valid;
    logic                 fb_ready;
    logic [PX_WIDTH-1:0]  fb_x;
    logic [PY_WIDTH-1:0]  fb_y;
    logic [23:0]          fb_rgb;
    logic                 err_overrun;

    always #5 clk = ~clk;

    pixel_resolve #(
        .RPP_WIDTH (RPP_WIDTH),
        .PX_WIDTH  (PX_WIDTH),
        .PY_WIDTH  (PY_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_start (pixel_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_busy  (pixel_busy),
        .color_wr_en (color_wr_en),
        .color_ndx   (color_ndx),
        .color       (color),
        .busy        (busy),
        .fb_valid    (fb_valid),
        .fb_ready    (fb_ready),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_rgb      (fb_rgb),
        .err_overrun (err_overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: real value of the float, scaled to 16 fractional bits and floored.
    function automatic int model_unorm(input logic [31:0] f);
        int  e;
        real v;
        e = int'(f[30:23]);
        if (f[31]) return 0;
        if (e == 255) return 65535;
        if (e == 0) return 0;
        v = real'(int'({1'b1, f[22:0]}));
        for (int k = e - 150; k < 0; k++) v = v / 2.0;
        for (int k = e - 150; k > 0; k--) v = v * 2.0;
        if (v >= 1.0) return 65535;
        return $rtoi(v * 65536.0);
    endfunction

    logic [95:0] m_ray [RPP];
    bit          m_vld [RPP];

    function automatic logic [23:0] model_rgb();
        logic [23:0] res;
        logic [31:0] w;
        int          s;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int i = 0; i < RPP; i++) begin
                w = 32'(m_ray[i] >> (64 - 32 * ch));
                if (m_vld[i]) s += model_unorm(w);
            end
            res = (res << 8) | 24'(((s / RPP) / 256) % 256);
        end
        return res;
    endfunction

    logic                chk_en    = 1'b0;
    logic                exp_busy  = 1'b0;
    logic                exp_valid = 1'b0;
    logic                exp_err   = 1'b0;
    logic [23:0]         exp_rgb   = '0;
    logic [PX_WIDTH-1:0] exp_x     = '0;
    logic [PY_WIDTH-1:0] exp_y     = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("fb_valid", 32'(fb_valid), 32'(exp_valid));
            check("err_overrun", 32'(err_overrun), 32'(exp_err));
            if (exp_valid) begin
                check("fb_rgb", 32'(fb_rgb), 32'(exp_rgb));
                check("fb_x", 32'(fb_x), 32'(exp_x));
                check("fb_y", 32'(fb_y), 32'(exp_y));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int          q_ndx [$];
    logic [95:0] q_col [$];

    task automatic add(input int ndx, input logic [95:0] c);
        q_ndx.push_back(ndx);
        q_col.push_back(c);
    endtask

    task automatic add_all(input logic [31:0] f);
        for (int i = 0; i < RPP; i++) add(i, {f, f, f});
    endtask

    task automatic start_and_write(input logic [PX_WIDTH-1:0] x, input logic [PY_WIDTH-1:0] y);
        cyc();
        pixel_start = 1'b1;
        pixel_x     = x;
        pixel_y     = y;
        for (int i = 0; i < RPP; i++) m_vld[i] = 1'b0;
        cyc();
        pixel_start = 1'b0;
        pixel_busy  = 1'b1;
        exp_busy    = 1'b1;
        for (int i = 0; i < q_ndx.size(); i++) begin
            cyc();
            color_wr_en = 1'b1;
            color_ndx   = RPP_WIDTH'(q_ndx[i]);
            color       = q_col[i];
            m_ray[q_ndx[i]] = q_col[i];
            m_vld[q_ndx[i]] = 1'b1;
        end
        q_ndx.delete();
        q_col.delete();
        cyc();
        color_wr_en = 1'b0;
        pixel_busy  = 1'b0;
    endtask

    task automatic run_pixel(input logic [PX_WIDTH-1:0] x, input logic [PY_WIDTH-1:0] y,
                             input int hold, input logic [23:0] lit);
        start_and_write(x, y);
        repeat (RPP + 2) cyc();
        cyc();
        exp_valid = 1'b1;
        exp_rgb   = model_rgb();
        exp_x     = x;
        exp_y     = y;
        fb_ready  = (hold == 0);
        @(negedge clk);
        check("rgb_literal", 32'(fb_rgb), 32'(lit));
        for (int i = 1; i <= hold; i++) begin
            cyc();
            fb_ready = (i == hold);
        end
        cyc();
        fb_ready  = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        pixel_start = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        pixel_busy  = 1'b0;
        color_wr_en = 1'b0;
        color_ndx   = '0;
        color       = '0;
        fb_ready    = 1'b0;
        for (int i = 0; i < RPP; i++) begin
            m_ray[i] = '0;
            m_vld[i] = 1'b0;
        end

        check("model_one", 32'(model_unorm(F_ONE)), 32'hFFFF);
        check("model_half", 32'(model_unorm(F_HALF)), 32'h8000);
        check("model_quarter", 32'(model_unorm(32'h3e800000)), 32'h4000);
        check("model_neg", 32'(model_unorm(F_NEG1)), 32'h0);
        check("model_nan", 32'(model_unorm(F_NAN)), 32'hFFFF);
        check("model_tiny", 32'(model_unorm(32'h33000000)), 32'h0);

        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_fb_x", 32'(fb_x), 32'h0);
        check("rst_fb_y", 32'(fb_y), 32'h0);
        check("rst_fb_rgb", 32'(fb_rgb), 32'h0);
        cyc();
        rst = 1'b0;

        add_all(F_ONE);
        run_pixel(10'd3, 10'd7, 0, 24'hFFFFFF);

        add_all(F_HALF);
        run_pixel(10'd4, 10'd7, 0, 24'h808080);

        for (int i = 0; i < RPP; i++) begin
            if (i < RPP / 2) add(i, {F_ONE, F_ONE, F_ONE});
            else add(i, 96'h0);
        end
        run_pixel(10'd5, 10'd8, 0, 24'h7F7F7F);

        add(0, {F_ONE, 32'h0, 32'h0});
        run_pixel(10'd6, 10'd9, 5, 24'h030000);

        add(5, {F_NEG1, F_NEG1, F_NEG1});
        add(5, {F_TWO, F_TWO, F_TWO});
        add(6, {F_NAN, F_NAN, F_NAN});
        run_pixel(10'd1023, 10'd1022, 2, 24'h070707);

        // second pixel_start while collecting
        cyc();
        pixel_start = 1'b1;
        pixel_x     = 10'd9;
        pixel_y     = 10'd9;
        cyc();
        pixel_start = 1'b0;
        pixel_busy  = 1'b1;
        exp_busy    = 1'b1;
        cyc();
        pixel_start = 1'b1;
        cyc();
        pixel_start = 1'b0;
        exp_err     = 1'b1;
        cyc();
        rst = 1'b1;
        pixel_busy = 1'b0;
        cyc();
        rst      = 1'b0;
        exp_busy = 1'b0;
        exp_err  = 1'b0;

        // stray write and reset while reading
        add(3, {F_ONE, F_ONE, F_ONE});
        start_and_write(10'd2, 10'd2);
        cyc();
        cyc();
        color_wr_en = 1'b1;
        color_ndx   = '0;
        color       = {F_ONE, F_ONE, F_ONE};
        cyc();
        color_wr_en = 1'b0;
        exp_err     = 1'b1;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        exp_busy = 1'b0;
        exp_err  = 1'b0;
        repeat (2) cyc();

        add(0, {F_ONE, 32'h0, 32'h0});
        run_pixel(10'd11, 10'd12, 0, 24'h030000);

        repeat (3) cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
